// File: rtl/aes_selftest_sequencer.sv
// Built-in self-test sequencer for the AES cipher/inverse-cipher cores.
// Steps each enabled core through a run window, checks its final state and exports it for display.
module aes_selftest_sequencer #(
  parameter logic [2:0]  MODE_MASK  = 3'b111,
  parameter bit          CONTINUOUS = 1'b1,
  parameter int unsigned LAT_EXTRA  = 0,
  parameter int unsigned DISP_BYTE  = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         start,
  input  logic [0:127] plaintext,
  input  logic [0:383] exp_ct,
  input  logic [0:767] state_in,
  output logic [5:0]   core_en,
  output logic [4:0]   round_cnt,
  output logic         busy,
  output logic         done,
  output logic         success,
  output logic [5:0]   pass_flags,
  output logic         fail,
  output logic [7:0]   err_cnt,
  output logic [0:127] disp_out,
  output logic [7:0]   disp_byte
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // First slot of the lowest enabled key size; both slots of a mode are always enabled together.
  function automatic logic [2:0] f_first_slot(input logic [2:0] mask);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      if (mask[k]) s = {2'(k), 1'b0};
    end
    return s;
  endfunction

  localparam logic [2:0] FIRST_SLOT = f_first_slot(MODE_MASK);

  state_t       r_state;
  logic [2:0]   r_slot;
  logic [5:0]   r_core_en;
  logic [4:0]   r_round_cnt;
  logic         r_busy;
  logic         r_done;
  logic         r_success;
  logic [5:0]   r_pass_flags;
  logic         r_fail;
  logic [7:0]   r_err_cnt;

  logic [4:0]   w_last_rnd;
  logic [2:0]   w_next_slot;
  logic         w_is_last;
  logic [0:127] w_slot_state;
  logic [0:127] w_expect;
  logic         w_match;
  logic         w_active;

  // Window ends at Nr + LAT_EXTRA, with Nr = 10 + 2*mode.
  assign w_last_rnd   = 5'(LAT_EXTRA) + 5'd10 + {2'b00, r_slot[2:1], 1'b0};
  assign w_slot_state = state_in[{r_slot, 7'd0} +: 128];
  assign w_expect     = r_slot[0] ? plaintext : exp_ct[{r_slot[2:1], 7'd0} +: 128];
  assign w_match      = (w_slot_state == w_expect);
  assign w_active     = (r_state == S_RUN) || (r_state == S_CHECK);

  // After a cipher slot comes its inverse; after an inverse, the next enabled mode's cipher.
  always_comb begin
    w_next_slot = r_slot;
    w_is_last   = 1'b1;
    if (!r_slot[0]) begin
      w_next_slot = r_slot + 3'd1;
      w_is_last   = 1'b0;
    end else begin
      for (int k = 2; k >= 0; k--) begin
        if (MODE_MASK[k] && (2'(k) > r_slot[2:1])) begin
          w_next_slot = {2'(k), 1'b0};
          w_is_last   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_slot       <= 3'd0;
      r_core_en    <= 6'd0;
      r_round_cnt  <= 5'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_pass_flags <= 6'd0;
      r_fail       <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else if (enable) begin
      r_done    <= 1'b0;
      r_success <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && (MODE_MASK != 3'b000)) begin
            r_pass_flags <= 6'd0;
            r_fail       <= 1'b0;
            r_err_cnt    <= 8'd0;
            r_slot       <= FIRST_SLOT;
            r_core_en    <= 6'd1 << FIRST_SLOT;
            r_round_cnt  <= 5'd0;
            r_busy       <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_round_cnt == w_last_rnd) begin
            r_state <= S_CHECK;
          end else begin
            r_round_cnt <= r_round_cnt + 5'd1;
          end
        end
        S_CHECK: begin
          r_pass_flags[r_slot] <= w_match;
          if (w_match) begin
            r_success <= 1'b1;
          end else begin
            r_fail <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
          r_round_cnt <= 5'd0;
          if (!w_is_last) begin
            r_slot    <= w_next_slot;
            r_core_en <= 6'd1 << w_next_slot;
            r_state   <= S_RUN;
          end else begin
            r_done <= 1'b1;
            if (CONTINUOUS) begin
              r_slot    <= FIRST_SLOT;
              r_core_en <= 6'd1 << FIRST_SLOT;
              r_state   <= S_RUN;
            end else begin
              r_core_en <= 6'd0;
              r_busy    <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      // Frozen: hold everything but never stretch a pulse.
      r_done    <= 1'b0;
      r_success <= 1'b0;
    end
  end

  assign core_en    = r_core_en;
  assign round_cnt  = r_round_cnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign success    = r_success;
  assign pass_flags = r_pass_flags;
  assign fail       = r_fail;
  assign err_cnt    = r_err_cnt;
  assign disp_out   = w_active ? w_slot_state : plaintext;
  assign disp_byte  = disp_out[8*DISP_BYTE +: 8];

endmodule

// File: doc/aes_selftest_sequencer.md
# aes_selftest_sequencer

Parametrised built-in self-test sequencer for the AES datapath. It steps the cipher and inverse-cipher cores of each enabled key size (128/192/256) through fixed run windows and compares each final state against expected values. It records per-check pass/fail and an error count, and exports the current state plus one selected byte for the BCD/seven-segment display path. It sits between the key-size core instances and the display encoder, replacing hard-coded round-number decoding with a handshake-driven FSM.

## Interface
- MODE_MASK, 3'b111, enabled key sizes: bit0 AES-128 (Nr=10), bit1 AES-192 (Nr=12), bit2 AES-256 (Nr=14)
- CONTINUOUS, 1, 1 = restart the pass automatically; 0 = stop in DONE
- LAT_EXTRA, 0, extra cycles (0..15) added to every run window for pipelined cores
- DISP_BYTE, 15, byte index (0 = MSB byte) of disp_out driven on disp_byte
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  high = advance; low = freeze all state, start ignored
- start  in  1  one-cycle request, honoured only in IDLE or DONE
- plaintext  in  [0:127]  test plaintext, also the expected decrypt result
- exp_ct  in  [0:383]  expected ciphertext, mode k at [128k +: 128]
- state_in  in  [0:767]  core outputs, slot s at [128s +: 128]; slot 2k = cipher k, 2k+1 = inverse k
- core_en  out  6  one-hot core enable, bit s = slot s
- round_cnt  out  5  cycle index inside the current run window
- busy  out  1  high in RUN/CHECK
- done  out  1  one-cycle pulse at end of each pass
- success  out  1  one-cycle pulse after a passing check
- pass_flags  out  6  bit s = result of latest check of slot s
- fail  out  1  sticky, any check failed since reset/start
- err_cnt  out  8  failed checks, saturates at 255
- disp_out  out  [0:127]  displayed state
- disp_byte  out  8  disp_out[8*DISP_BYTE +: 8]

## Operation
- States: IDLE, RUN, CHECK, DONE.
- Step order: slots 0,1,2,3,4,5; slots of disabled modes are skipped.
- IDLE/DONE + start (enable high, MODE_MASK≠0):
  - clear pass_flags, fail, err_cnt;
  - go to RUN at the first enabled slot, with round_cnt=0.
- MODE_MASK=0: start is ignored and the FSM stays in IDLE.
- RUN:
  - core_en = one-hot of the current slot;
  - round_cnt increments every cycle from 0 to Nr+LAT_EXTRA, then the FSM enters CHECK.
- CHECK (one cycle):
  - core_en is held;
  - compare state_in slot s to exp_ct[mode] for even s, or to plaintext for odd s;
  - at the exit edge:
    - pass_flags[s] takes the result;
    - on pass, success=1 for one cycle;
    - on fail, fail=1 and err_cnt increments (saturating).
- After CHECK: go to the next enabled slot's RUN with round_cnt=0. If this was the last slot:
  - pulse done;
  - if CONTINUOUS=1, go to RUN of the first enabled slot, leaving flags uncleared (fail and err_cnt accumulate);
  - if CONTINUOUS=0, go to DONE.
- disp_out = plaintext in IDLE/DONE; otherwise the state_in slot of the current step.
- core_en = 0 in IDLE/DONE.

## Timing
- Reset values: FSM IDLE, core_en 0, round_cnt 0, busy 0, done 0, success 0, pass_flags 0, fail 0, err_cnt 0.
  - disp_out = plaintext.
  - reset mid-run gives these values in the cycle after the reset edge.
- Latency:
  - start sampled at edge t; RUN with core_en asserted is visible from t+1.
  - Step length = Nr+LAT_EXTRA+2 cycles: Nr+1+LAT_EXTRA in RUN plus 1 in CHECK.
  - Full 3-mode pass, LAT_EXTRA=0: 2·(12+14+16) = 84 cycles.
- done, success and the pass_flags/fail/err_cnt updates all appear in the cycle after CHECK.
- enable low:
  - the FSM, round_cnt, core_en and all flags hold;
  - done/success pulses are not generated or extended.
  - A pause adds exactly its length to the pass time.
- start while busy: ignored. start and reset in the same cycle: reset wins.
- disp_out/disp_byte are combinational from state and inputs.

## Test plan
1. **Ideal core model, MODE_MASK=111, CONTINUOUS=0, start once.**
   - core_en steps 01,02,04,08,10,20 with RUN windows 11,11,13,13,15,15 cycles.
   - done 84 cycles after RUN entry; pass_flags=6'h3F, fail=0, err_cnt=0, FSM in DONE.
2. **Flip bit 0 of the slot-2 (AES-192 cipher) output.**
   - pass_flags=6'h3B, fail=1, err_cnt=1, no success pulse for slot 2.
   - Remaining slots are still checked; done still at 84.
3. **MODE_MASK=101, LAT_EXTRA=2.**
   - Only slots 0,1,4,5 are enabled, with windows 13,13,17,17.
   - Pass length 64; core_en never 04 or 08.
4. **CONTINUOUS=1, slot 5 output permanently wrong, 300 passes.**
   - One done per pass; err_cnt reaches 255 and holds; fail stays 1.
5. **Pause, reset and ignored start.**
   - enable low for 5 cycles mid-RUN of slot 3: round_cnt and core_en frozen, pass completes at 89.
   - reset mid-RUN: all outputs return to reset values the next cycle.
   - start pulsed while busy: no effect.
6. **Display byte, plaintext 00112233445566778899aabbccddeeff in IDLE.**
   - DISP_BYTE=15 gives disp_byte=8'hff; DISP_BYTE=0 gives 8'h00.
   - In RUN of slot 0, disp_out tracks state_in[0:127].
